// File: rtl/ring_ctr_pkg.sv
// Shared mode encodings for the ring/Johnson counter family.
package ring_ctr_pkg;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_HOLD    = 2'b10
    } ring_mode_t;

endpackage

// File: rtl/ring_period_tracker.sv
// Step counter and registered wrap pulse for ring_counter_gen.
// Counts active steps; the step that reaches `period` restarts the count
// and raises `wrap` for one cycle. `clear` restarts without a pulse.
module ring_period_tracker #(
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          clear,
    input  logic [CW-1:0] period,
    output logic          wrap
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);

    // Next step count and wrap; clear takes priority over a step.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (step) begin
            if (cnt_inc == period) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Step-count and wrap registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: rtl/ring_counter_gen.sv
// Parametrised ring / Johnson counter with direction select, clock enable,
// synchronous parallel load, all-zeros lockout recovery and a one-cycle
// wrap pulse per completed period.
module ring_counter_gen
    import ring_ctr_pkg::*;
#(
    parameter int unsigned    W         = 8,
    parameter logic [W-1:0]   RESET_VAL = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] init,
    input  logic [1:0]   mode,
    input  logic         dir,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam int unsigned CW = $clog2(2 * W) + 1;

    logic [W-1:0]  count_q, count_d;
    logic [1:0]    mode_q, mode_d;
    logic          step;
    logic          clear;
    logic [CW-1:0] period;

    // Shift / load / lockout next-state and step-counter control.
    always_comb begin
        count_d = count_q;
        mode_d  = mode;
        step    = 1'b0;
        clear   = 1'b0;
        period  = (mode == MODE_JOHNSON) ? CW'(2 * W) : CW'(W);
        if (load) begin
            count_d = init;
            clear   = 1'b1;
        end else if (en) begin
            case (mode)
                MODE_RING: begin
                    if (count_q == '0) begin
                        // Stuck all-zeros pattern: restart from the reset code.
                        count_d = RESET_VAL;
                        clear   = 1'b1;
                    end else begin
                        count_d = dir ? {count_q[0], count_q[W-1:1]}
                                      : {count_q[W-2:0], count_q[W-1]};
                        step    = 1'b1;
                    end
                end
                MODE_JOHNSON: begin
                    count_d = dir ? {~count_q[0], count_q[W-1:1]}
                                  : {count_q[W-2:0], ~count_q[W-1]};
                    step    = 1'b1;
                end
                default: ; // MODE_HOLD and the reserved code both hold
            endcase
        end
        // A mode change restarts the period; the shift above still applies.
        if (mode != mode_q) begin
            clear = 1'b1;
        end
    end

    // Counter state and previous-mode registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RESET_VAL;
            mode_q  <= MODE_RING;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    ring_period_tracker #(
        .CW (CW)
    ) u_tracker (
        .clk    (clk),
        .rst_n  (rst),
        .step   (step),
        .clear  (clear),
        .period (period),
        .wrap   (wrap)
    );

    assign count = count_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Scoreboard bench for ring_counter_gen (W=8, RESET_VAL=1): the driver
// pushes hand-computed {count, wrap} after each edge, a monitor pops and
// compares one sample per edge.
module tb_ring_counter_gen;

    typedef struct packed {
        logic [7:0]  c;
        logic        w;
        int unsigned idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] init = '0;
    logic [1:0] mode = 2'b00;
    logic       dir = 1'b0;
    logic [7:0] count;
    logic       wrap;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned vec_idx = 0;
    exp_t        sb[$];

    ring_counter_gen #(
        .W         (8),
        .RESET_VAL (8'h01)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .init  (init),
        .mode  (mode),
        .dir   (dir),
        .count (count),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs at the negedge and queue the expected result.
    task automatic vec(input logic ld, input logic e, input logic [1:0] m,
                       input logic d, input logic [7:0] iv,
                       input logic [7:0] ec, input logic ew);
        exp_t x;
        @(negedge clk);
        load = ld; en = e; mode = m; dir = d; init = iv;
        @(posedge clk);
        x.c = ec; x.w = ew; x.idx = vec_idx;
        vec_idx++;
        sb.push_back(x);
    endtask

    // Monitor: one sample per rising edge, away from the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_cmp++;
                if (count !== x.c || wrap !== x.w) begin
                    n_bad++;
                    $display("FAIL vec%0d: count=%h wrap=%b, expected count=%h wrap=%b",
                             x.idx, count, wrap, x.c, x.w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rseq[8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        logic [7:0] lseq[8]  = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};
        logic [7:0] jseq[16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        logic [7:0] jdn[13]  = '{8'h03, 8'h01, 8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0,
                                 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h7F, 8'h3F};

        // Reset state, checked while reset is held.
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (count !== 8'h01 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: count=%h wrap=%b, expected count=01 wrap=0", count, wrap);
        end
        @(negedge clk);
        rst = 1'b1;

        // Ring, toward MSB: wrap only on the return to 01.
        for (int i = 0; i < 8; i++) vec(0, 1, 2'b00, 0, 8'h00, rseq[i], i == 7);
        vec(0, 1, 2'b00, 0, 8'h00, 8'h02, 0);

        // Load zero in Johnson mode, then a full 16-step Johnson period.
        vec(1, 1, 2'b01, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 16; i++) vec(0, 1, 2'b01, 0, 8'h00, jseq[i], i == 15);

        // Load 03 with en high: no step counted, period counted from the load.
        vec(1, 1, 2'b00, 0, 8'h03, 8'h03, 0);
        for (int i = 0; i < 8; i++) vec(0, 1, 2'b00, 0, 8'h00, lseq[i], i == 7);

        // Lockout recovery from zero, then one period yields one wrap.
        vec(1, 1, 2'b00, 0, 8'h00, 8'h00, 0);
        vec(0, 1, 2'b00, 0, 8'h00, 8'h01, 0);
        for (int i = 0; i < 8; i++) vec(0, 1, 2'b00, 0, 8'h00, rseq[i], i == 7);

        // Hold via en=0, hold via mode=10, then resume ring.
        vec(0, 0, 2'b00, 0, 8'h00, 8'h01, 0);
        vec(0, 1, 2'b10, 0, 8'h00, 8'h01, 0);
        vec(0, 1, 2'b00, 0, 8'h00, 8'h02, 0);

        // Direction toggles, then ring->Johnson at the 4th edge after load.
        vec(1, 0, 2'b00, 0, 8'h01, 8'h01, 0);
        vec(0, 1, 2'b00, 0, 8'h00, 8'h02, 0);
        vec(0, 1, 2'b00, 1, 8'h00, 8'h01, 0);
        vec(0, 1, 2'b00, 1, 8'h00, 8'h80, 0);
        vec(0, 1, 2'b01, 0, 8'h00, 8'h00, 0);
        vec(0, 1, 2'b01, 0, 8'h00, 8'h01, 0);
        vec(0, 1, 2'b01, 0, 8'h00, 8'h03, 0);
        vec(0, 1, 2'b01, 0, 8'h00, 8'h07, 0);
        for (int i = 0; i < 13; i++) vec(0, 1, 2'b01, 1, 8'h00, jdn[i], i == 12);

        // Asynchronous reset while wrap is high.
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (count !== 8'h01 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: count=%h wrap=%b, expected count=01 wrap=0", count, wrap);
        end
        @(negedge clk);
        en = 1'b0; load = 1'b0; mode = 2'b00; dir = 1'b0;
        rst = 1'b1;
        vec(0, 1, 2'b00, 0, 8'h00, 8'h02, 0);
        vec(0, 1, 2'b00, 0, 8'h00, 8'h04, 0);

        // Every queued expectation must have been consumed.
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d, expected pending=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
